// File: rtl/branch_cond_unit.sv
// Branch condition resolution: NZCV flag register, B.cond/CBZ/CBNZ/B evaluation
// through a one-deep valid/ready output buffer, and saturating statistics counters.
module branch_cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       alu_status,
    input  logic             flag_we,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic [3:0]       req_cond,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_taken,
    output logic [3:0]       flags,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] eval_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        KIND_BCOND = 2'b00,
        KIND_CBZ   = 2'b01,
        KIND_CBNZ  = 2'b10,
        KIND_B     = 2'b11
    } kind_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    kind_e      kind;
    logic [3:0] eff;
    logic       flag_z, flag_n, flag_c, flag_v;
    logic       cond_true;
    logic       taken;
    logic       accept;

    assign kind      = kind_e'(req_kind);
    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;

    // A same-cycle flag-setting result overrides the registered flags.
    assign eff    = flag_we ? alu_status : flags;
    assign flag_z = eff[0];
    assign flag_n = eff[1];
    assign flag_c = eff[2];
    assign flag_v = eff[3];

    always_comb begin
        cond_true = 1'b0;
        case (req_cond)
            4'h0: cond_true = flag_z;
            4'h1: cond_true = !flag_z;
            4'h2: cond_true = flag_c;
            4'h3: cond_true = !flag_c;
            4'h4: cond_true = flag_n;
            4'h5: cond_true = !flag_n;
            4'h6: cond_true = flag_v;
            4'h7: cond_true = !flag_v;
            4'h8: cond_true = flag_c && !flag_z;
            4'h9: cond_true = !flag_c || flag_z;
            4'hA: cond_true = (flag_n == flag_v);
            4'hB: cond_true = (flag_n != flag_v);
            4'hC: cond_true = !flag_z && (flag_n == flag_v);
            4'hD: cond_true = flag_z || (flag_n != flag_v);
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (kind)
            KIND_BCOND: taken = cond_true;
            KIND_CBZ:   taken = alu_status[0];
            KIND_CBNZ:  taken = !alu_status[0];
            KIND_B:     taken = 1'b1;
            default:    taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (flag_we) begin
            flags <= alu_status;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_taken <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_taken <= taken;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_cnt  <= '0;
            taken_cnt <= '0;
        end else if (cnt_clr) begin
            eval_cnt  <= '0;
            taken_cnt <= '0;
        end else if (accept) begin
            if (eval_cnt != '1) begin
                eval_cnt <= eval_cnt + CNT_ONE;
            end
            if (taken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed sweeps plus random traffic
// compared against a behavioural model of the flag/handshake/counter rules.
module tb_branch_cond_unit;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   alu_status;
    logic         flag_we;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_kind;
    logic [3:0]   req_cond;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_taken;
    logic [3:0]   flags;
    logic         cnt_clr;
    logic [W-1:0] eval_cnt;
    logic [W-1:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [3:0] m_flags;
    bit         m_rv;
    bit         m_rt;
    int         m_eval;
    int         m_taken;

    branch_cond_unit #(.CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .alu_status(alu_status), .flag_we(flag_we),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_cond(req_cond), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_taken(resp_taken), .flags(flags), .cnt_clr(cnt_clr),
        .eval_cnt(eval_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Conditions come in complementary pairs; odd codes invert the even base, except AL/NV.
    function automatic bit cond_holds(input logic [3:0] f, input logic [3:0] c);
        bit z, n, cy, v, r;
        logic [2:0] base;
        z = f[0]; n = f[1]; cy = f[2]; v = f[3];
        base = c[3:1];
        case (base)
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && base != 3'd7) r = !r;
        return r;
    endfunction

    function automatic int sat_inc(input int x);
        return (x >= MAX) ? MAX : x + 1;
    endfunction

    task automatic model_reset();
        m_flags = 4'h0; m_rv = 0; m_rt = 0; m_eval = 0; m_taken = 0;
    endtask

    // One clock with the currently driven inputs; checks req_ready before the edge and
    // all registered outputs after it.
    task automatic cycle();
        bit rdy, acc, tk;
        logic [3:0] eff;
        #1;
        rdy = !m_rv || resp_ready;
        chk("req_ready", {31'b0, req_ready}, {31'b0, rdy});
        acc = req_valid && rdy;
        eff = flag_we ? alu_status : m_flags;
        case (req_kind)
            2'd0: tk = cond_holds(eff, req_cond);
            2'd1: tk = alu_status[0];
            2'd2: tk = !alu_status[0];
            default: tk = 1'b1;
        endcase
        @(posedge clk);
        #1;
        if (flag_we) m_flags = alu_status;
        if (acc) begin
            m_rv = 1; m_rt = tk;
        end else if (resp_ready) begin
            m_rv = 0;
        end
        if (cnt_clr) begin
            m_eval = 0; m_taken = 0;
        end else if (acc) begin
            m_eval = sat_inc(m_eval);
            if (tk) m_taken = sat_inc(m_taken);
        end
        chk("flags", {28'b0, flags}, {28'b0, m_flags});
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_rv});
        chk("resp_taken", {31'b0, resp_taken}, {31'b0, m_rt});
        chk("eval_cnt", {28'b0, eval_cnt}, m_eval);
        chk("taken_cnt", {28'b0, taken_cnt}, m_taken);
    endtask

    task automatic idle_inputs();
        flag_we = 0; req_valid = 0; req_kind = 0; req_cond = 0;
        resp_ready = 1; cnt_clr = 0; alu_status = 4'h0;
    endtask

    task automatic load_flags(input logic [3:0] f);
        idle_inputs();
        flag_we = 1; alu_status = f;
        cycle();
    endtask

    task automatic request(input logic [1:0] k, input logic [3:0] c,
                           input logic we, input logic [3:0] st);
        idle_inputs();
        req_valid = 1; req_kind = k; req_cond = c; flag_we = we; alu_status = st;
        cycle();
    endtask

    initial begin
        bit held;
        idle_inputs();
        model_reset();
        rst_n = 0;
        #12;
        chk("rst_flags", {28'b0, flags}, 0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        chk("rst_req_ready", {31'b0, req_ready}, 1);
        rst_n = 1;

        // Condition sweep over every flag pattern and condition code
        for (int s = 0; s < 16; s++) begin
            for (int c = 0; c < 16; c++) begin
                load_flags(4'(s));
                request(2'd0, 4'(c), 1'b0, 4'($urandom_range(15)));
            end
        end
        load_flags(4'b1000);
        request(2'd0, 4'hA, 1'b0, 4'h0);
        chk("ge_v1n0", {31'b0, resp_taken}, 0);
        request(2'd0, 4'hB, 1'b0, 4'h0);
        chk("lt_v1n0", {31'b0, resp_taken}, 1);

        // Bypass vs registered flags
        load_flags(4'h0);
        request(2'd0, 4'h0, 1'b1, 4'b0001);
        chk("bypass_eq", {31'b0, resp_taken}, 1);
        load_flags(4'h0);
        request(2'd0, 4'h0, 1'b0, 4'b0001);
        chk("nobypass_eq", {31'b0, resp_taken}, 0);

        // CBZ / CBNZ / B
        request(2'd1, 4'h0, 1'b0, 4'b0001);
        chk("cbz_z1", {31'b0, resp_taken}, 1);
        request(2'd2, 4'h0, 1'b0, 4'b0001);
        chk("cbnz_z1", {31'b0, resp_taken}, 0);
        request(2'd1, 4'h0, 1'b0, 4'b0000);
        chk("cbz_z0", {31'b0, resp_taken}, 0);
        request(2'd2, 4'h0, 1'b0, 4'b0000);
        chk("cbnz_z0", {31'b0, resp_taken}, 1);
        request(2'd3, 4'h1, 1'b0, 4'b0000);
        chk("b_taken", {31'b0, resp_taken}, 1);

        // Counter saturation at 15 after 20 taken accepts
        idle_inputs(); cnt_clr = 1; cycle();
        for (int i = 0; i < 20; i++) request(2'd3, 4'h0, 1'b0, 4'h0);
        chk("sat_eval", {28'b0, eval_cnt}, 15);
        chk("sat_taken", {28'b0, taken_cnt}, 15);
        idle_inputs(); req_valid = 1; req_kind = 2'd3; cnt_clr = 1; cycle();
        chk("clr_eval", {28'b0, eval_cnt}, 0);
        chk("clr_taken", {28'b0, taken_cnt}, 0);
        chk("clr_resp_valid", {31'b0, resp_valid}, 1);

        // Backpressure: response held, new request waits, flags still update
        idle_inputs(); cnt_clr = 1; cycle();
        request(2'd1, 4'h0, 1'b0, 4'b0001);
        held = resp_taken;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            resp_ready = 0; req_valid = 1; req_kind = 2'd2; alu_status = 4'b0001;
            flag_we = (i == 1);
            cycle();
            chk("stall_taken_stable", {31'b0, resp_taken}, {31'b0, held});
        end
        chk("stall_eval_once", {28'b0, eval_cnt}, 1);
        idle_inputs(); req_valid = 1; req_kind = 2'd2; alu_status = 4'b0001; cycle();
        chk("release_eval", {28'b0, eval_cnt}, 2);
        chk("release_taken", {31'b0, resp_taken}, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            alu_status = 4'($urandom_range(15));
            flag_we    = ($urandom_range(3) == 0);
            req_valid  = ($urandom_range(3) != 0);
            req_kind   = 2'($urandom_range(3));
            req_cond   = 4'($urandom_range(15));
            resp_ready = ($urandom_range(2) != 0);
            cnt_clr    = ($urandom_range(40) == 0);
            cycle();
        end

        // Reset mid-stream with a buffered response
        idle_inputs(); request(2'd3, 4'h0, 1'b1, 4'hF);
        idle_inputs(); resp_ready = 0; #1;
        rst_n = 0;
        #2;
        chk("midrst_resp_valid", {31'b0, resp_valid}, 0);
        chk("midrst_resp_taken", {31'b0, resp_taken}, 0);
        chk("midrst_flags", {28'b0, flags}, 0);
        chk("midrst_eval", {28'b0, eval_cnt}, 0);
        chk("midrst_taken", {28'b0, taken_cnt}, 0);
        chk("midrst_req_ready", {31'b0, req_ready}, 1);
        model_reset();
        rst_n = 1;
        request(2'd1, 4'h0, 1'b0, 4'b0001);
        chk("post_rst_accept", {28'b0, eval_cnt}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Condition-resolution stage paired with the datapath ALU. It consumes the ALU's 4-bit status vector and keeps the architectural NZCV flag register, updated only on flag-setting instructions. It resolves B.cond, CBZ, CBNZ and B requests through a one-deep valid/ready buffered pipeline stage, and keeps saturating statistics counters. It sits between the execute stage and the PC-select logic.

## Interface
- CNT_W, 16, width of the evaluation and taken statistics counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_status  in  4  ALU flags in ALU order {v, c, n, z}: bit3=V, bit2=C, bit1=N, bit0=Z
- flag_we  in  1  capture alu_status into the flag register this edge
- req_valid  in  1  branch evaluation request valid
- req_ready  out  1  unit can accept a request this cycle
- req_kind  in  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 B (unconditional)
- req_cond  in  4  condition code, used only for B.cond
- resp_valid  out  1  result held in output buffer
- resp_ready  in  1  downstream accepts result
- resp_taken  out  1  branch taken
- flags  out  4  current flag register, {V, C, N, Z}
- cnt_clr  in  1  synchronous clear of both counters
- eval_cnt  out  CNT_W  accepted requests, saturating
- taken_cnt  out  CNT_W  accepted requests resolved taken, saturating

## Operation
- Flag register: on a clk edge with flag_we=1, flags <= alu_status. Otherwise flags hold. No other source writes flags.
- Accept: a request is accepted on an edge where req_valid & req_ready = 1.
- req_ready = !resp_valid | resp_ready. This is combinational, so the unit sustains one request per cycle when downstream is ready.
- Effective flags for B.cond:
  - alu_status when flag_we=1 in the accept cycle (bypass; the same-cycle flag-setting result wins).
  - Otherwise the flags register.
- CBZ is taken iff alu_status[0]=1 in the accept cycle (ALU passes the tested register through). CBNZ is the inverse.
- B is always taken. req_cond is ignored for CBZ, CBNZ and B.
- B.cond on effective flags F:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 HS: C. 3 LO: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F NV: 1.
- Output buffer:
  - On accept, resp_valid <= 1 and resp_taken <= the computed result.
  - When resp_valid & resp_ready and there is no accept, resp_valid <= 0.
  - While resp_valid=1 & resp_ready=0, resp_valid and resp_taken hold stable.
- Counters:
  - On accept, eval_cnt increments; taken_cnt also increments if the result is taken.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 clears both to 0 and takes priority over a same-cycle increment; that increment is lost.

## Timing
- Reset (rst_n=0, asynchronous, immediate): flags=0000, resp_valid=0, resp_taken=0, eval_cnt=0, taken_cnt=0. req_ready=1 follows combinationally.
- Reset asserted mid-operation discards any buffered response. Counters and flags return to 0 regardless of pending requests. The first edge after rst_n rises may accept a request.
- Latency: one cycle. A request accepted at edge k has resp_valid/resp_taken visible after edge k. The flag update from flag_we at edge k is visible on flags after edge k.
- Back-to-back: with resp_ready held 1, one request is accepted per cycle and resp_valid stays 1 continuously.
- Stall: resp_ready=0 with resp_valid=1 gives req_ready=0. req_valid may be held; no request is dropped or duplicated.
- flag_we is independent of the request handshake. Flags update even when req_ready=0. A stalled request that is accepted later uses the flags (or bypass) of its actual accept cycle.

## Test plan
- Reset/defaults: assert rst_n=0 mid-stream with resp_valid=1 -> outputs immediately 0. After release, req_ready=1 and flags=0000.
- Condition sweep: for each alu_status 0..15, load via flag_we, then issue B.cond cond 0..F -> resp_taken matches the table. Example: flags V=1,N=0 (1000b), cond A (GE) -> 0; cond B (LT) -> 1.
- Bypass: flags=0000, same cycle flag_we=1, alu_status=0001, B.cond EQ -> taken=1. Without flag_we -> taken=0.
- CBZ/CBNZ/B: alu_status=0001 -> CBZ taken, CBNZ not taken. alu_status=0000 -> the reverse. B taken regardless.
- Backpressure: resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, resp_taken stable, eval_cnt +1 only. Release -> the next request is accepted on the first ready cycle.
- Counters: CNT_W=4, 20 taken accepts -> eval_cnt=taken_cnt=15. cnt_clr coincident with an accept -> both 0 on the next cycle.
